// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the bit-interleaved TDM receive path: alignment FSM
// state encoding, a constant-evaluable ceil(log2) helper, and counter widths
// and frame length for the default configuration (2 lanes x 8-bit words).
// No ports.
// -----------------------------------------------------------------------------
package tdm_pkg;

    // Alignment state: HUNT waits for a frame marker, LOCKED tracks the frame.
    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // ceil(log2(value)), never less than 1 so a counter always has a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = 32'(i + 1);
            end else begin
                width = width;
            end
        end
        if (width == 32'd0) begin
            width = 32'd1;
        end else begin
            width = width;
        end
        return width;
    endfunction

    localparam int unsigned DEF_NUM_LANES = 32'd2;
    localparam int unsigned DEF_WORD_W    = 32'd8;
    localparam int unsigned LANE_CNT_W    = clog2(DEF_NUM_LANES);
    localparam int unsigned BIT_CNT_W     = clog2(DEF_WORD_W);
    localparam int unsigned FRAME_BITS    = DEF_NUM_LANES * DEF_WORD_W;

endpackage

// File: rtl/tdm_lane_deser.sv
// -----------------------------------------------------------------------------
// tdm_lane_deser
// One lane of the TDM receiver: MSB-first shift register, output word register
// and a one-cycle valid pulse when a word completes.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   shift_en   this lane owns the current accepted bit
//   in_bit     serial data bit
//   last_bit   the current bit is the final (LSB) bit of a word
//   flush      discard the partial word (a concurrent shift starts a new one)
//   word       last completed word, held until the next completion
//   valid      one-cycle pulse in the cycle after a word completes
// -----------------------------------------------------------------------------
module tdm_lane_deser
    import tdm_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              in_bit,
    input  logic              last_bit,
    input  logic              flush,
    output logic [WORD_W-1:0] word,
    output logic              valid
);

    logic [WORD_W-1:0] sr_r;
    logic [WORD_W-1:0] word_r;
    logic              valid_r;
    logic [WORD_W-1:0] shifted_s;

    assign shifted_s = {sr_r[WORD_W-2:0], in_bit};

    // Shift register, completed-word capture and valid pulse generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r    <= {WORD_W{1'b0}};
            word_r  <= {WORD_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (flush) begin
                // A flush that coincides with a shift is a realignment: the
                // incoming bit becomes the MSB of a fresh word.
                sr_r <= shift_en ? {{(WORD_W-1){1'b0}}, in_bit} : {WORD_W{1'b0}};
            end else if (shift_en) begin
                sr_r <= shifted_s;
            end else begin
                sr_r <= sr_r;
            end
            if (shift_en && last_bit && !flush) begin
                word_r  <= shifted_s;
                valid_r <= 1'b1;
            end else begin
                word_r  <= word_r;
            end
        end
    end

    assign word  = word_r;
    assign valid = valid_r;

endmodule

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Receive side of bit-level TDM: locks onto frame alignment using frame_sync,
// routes each accepted bit to its lane (bit n -> lane n mod NUM_LANES) and
// deserialises WORD_W bits per lane, MSB first.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_bit       serial data bit
//   in_valid     bit is meaningful; when low nothing advances
//   frame_sync   marks lane 0 / bit 0 of a frame (qualified by in_valid)
//   out_data     lane L word in bits [L*WORD_W +: WORD_W]
//   out_valid    one-cycle pulse per lane when its slice updates
//   locked       high while aligned
//   sync_err     one-cycle pulse on an unexpected or missing frame_sync
// -----------------------------------------------------------------------------
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned WORD_W    = DEF_WORD_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_bit,
    input  logic                          in_valid,
    input  logic                          frame_sync,
    output logic [NUM_LANES*WORD_W-1:0]   out_data,
    output logic [NUM_LANES-1:0]          out_valid,
    output logic                          locked,
    output logic                          sync_err
);

    localparam int unsigned     LC_W      = clog2(NUM_LANES);
    localparam int unsigned     BC_W      = clog2(WORD_W);
    localparam logic [LC_W-1:0] LANE_ZERO = {LC_W{1'b0}};
    localparam logic [LC_W-1:0] LANE_ONE  = LC_W'(1);
    localparam logic [LC_W-1:0] LANE_LAST = LC_W'(NUM_LANES - 1);
    localparam logic [BC_W-1:0] BIT_ZERO  = {BC_W{1'b0}};
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_W - 1);

    state_e          state_r;
    state_e          state_s;
    logic [LC_W-1:0] lane_cnt_r;
    logic [LC_W-1:0] lane_cnt_s;
    logic [BC_W-1:0] bit_cnt_r;
    logic [BC_W-1:0] bit_cnt_s;
    logic [LC_W-1:0] lane_sel_s;
    logic            shift_s;
    logic            flush_s;
    logic            last_s;
    logic            err_s;
    logic            at_start_s;
    logic            locked_r;
    logic            sync_err_r;

    assign at_start_s = (lane_cnt_r == LANE_ZERO) && (bit_cnt_r == BIT_ZERO);

    // Next-state, counter advance, lane steering and sync checking.
    always_comb begin
        state_s    = state_r;
        lane_cnt_s = lane_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        lane_sel_s = lane_cnt_r;
        shift_s    = 1'b0;
        flush_s    = 1'b0;
        last_s     = 1'b0;
        err_s      = 1'b0;
        if (in_valid) begin
            case (state_r)
                HUNT: begin
                    if (frame_sync) begin
                        // Marker found: this bit is lane 0 / bit 0.
                        flush_s    = 1'b1;
                        shift_s    = 1'b1;
                        lane_sel_s = LANE_ZERO;
                        lane_cnt_s = LANE_ONE;
                        bit_cnt_s  = BIT_ZERO;
                        state_s    = LOCKED;
                    end else begin
                        lane_cnt_s = LANE_ZERO;
                        bit_cnt_s  = BIT_ZERO;
                    end
                end
                LOCKED: begin
                    if (frame_sync && !at_start_s) begin
                        // Marker in the wrong place: drop partials and
                        // realign on this bit without leaving LOCKED.
                        err_s      = 1'b1;
                        flush_s    = 1'b1;
                        shift_s    = 1'b1;
                        lane_sel_s = LANE_ZERO;
                        lane_cnt_s = LANE_ONE;
                        bit_cnt_s  = BIT_ZERO;
                    end else if (!frame_sync && at_start_s) begin
                        // Marker missing where a frame must start.
                        err_s      = 1'b1;
                        flush_s    = 1'b1;
                        lane_cnt_s = LANE_ZERO;
                        bit_cnt_s  = BIT_ZERO;
                        state_s    = HUNT;
                    end else begin
                        shift_s = 1'b1;
                        last_s  = (bit_cnt_r == BIT_LAST);
                        if (lane_cnt_r == LANE_LAST) begin
                            lane_cnt_s = LANE_ZERO;
                            if (bit_cnt_r == BIT_LAST) begin
                                bit_cnt_s = BIT_ZERO;
                            end else begin
                                bit_cnt_s = bit_cnt_r + BC_W'(1);
                            end
                        end else begin
                            lane_cnt_s = lane_cnt_r + LC_W'(1);
                        end
                    end
                end
                default: begin
                    state_s    = HUNT;
                    lane_cnt_s = LANE_ZERO;
                    bit_cnt_s  = BIT_ZERO;
                    flush_s    = 1'b1;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state, position counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= HUNT;
            lane_cnt_r <= LANE_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            locked_r   <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            lane_cnt_r <= lane_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            locked_r   <= (state_s == LOCKED);
            sync_err_r <= err_s;
        end
    end

    assign locked   = locked_r;
    assign sync_err = sync_err_r;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic lane_hit_s;
        assign lane_hit_s = shift_s && (lane_sel_s == LC_W'(l));

        tdm_lane_deser #(
            .WORD_W(WORD_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .shift_en (lane_hit_s),
            .in_bit   (in_bit),
            .last_bit (last_s),
            .flush    (flush_s),
            .word     (out_data[l*WORD_W +: WORD_W]),
            .valid    (out_valid[l])
        );
    end

endmodule
